matrix_vector_product: RTL and testbench

Tiled signed fixed-point matrix–vector multiplier for the backpropagation datapath. It consumes an H×W weight/gradient matrix in the same flat row-major layout that `tensor_product` produces, plus a length-W vector, and returns the length-H reduction r[i] = Σj M[i][j]·v[j]. It is the reducing counterpart of the outer product, used to propagate deltas back through a layer. Operands are buffered and processed over several cycles under ready/valid handshakes.

---
 rtl/matrix_vector_product_if.sv | 40 ++++
 rtl/matrix_vector_product.sv | 192 +++++++++++++++++++
 tb/tb_matrix_vector_product.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_vector_product_if.sv
// matrix_vector_product_if
//   Operand/result bundle for matrix_vector_product.
//   matrix : H*W cells, cell [i][j] at bit (i*W+j)*MATRIX_CELL_WIDTH (row-major)
//   vector : W cells, cell j at bit j*VECTOR_CELL_WIDTH
//   result : H cells, cell i at bit i*RESULT_CELL_WIDTH
//   error  : some result cell overflowed in the current transaction
//   Each operand and the result use their own valid/ready pair.
//   Modports: master (producer/consumer side), slave (the multiplier).
interface matrix_vector_product_if #(
   parameter int MATRIX_HEIGHT     = 4,
   parameter int MATRIX_WIDTH      = 4,
   parameter int MATRIX_CELL_WIDTH = 8,
   parameter int VECTOR_CELL_WIDTH = 8,
   parameter int RESULT_CELL_WIDTH = 8
);
   logic [MATRIX_HEIGHT*MATRIX_WIDTH*MATRIX_CELL_WIDTH-1:0] matrix;
   logic                                                    matrix_valid;
   logic                                                    matrix_ready;
   logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]               vector;
   logic                                                    vector_valid;
   logic                                                    vector_ready;
   logic [MATRIX_HEIGHT*RESULT_CELL_WIDTH-1:0]              result;
   logic                                                    result_valid;
   logic                                                    result_ready;
   logic                                                    error;

   modport master (
      output matrix, matrix_valid, input matrix_ready,
      output vector, vector_valid, input vector_ready,
      input  result, result_valid, output result_ready,
      input  error
   );

   modport slave (
      input  matrix, matrix_valid, output matrix_ready,
      input  vector, vector_valid, output vector_ready,
      output result, result_valid, input result_ready,
      output error
   );
endinterface

// File: rtl/matrix_vector_product.sv
// matrix_vector_product
//   Tiled signed fixed-point r[i] = sum_j M[i][j]*v[j]. Operands are captured
//   independently, then CALC walks the matrix one TILING_ROW x TILING_COL tile
//   per cycle into full-precision per-row accumulators. Entering DONE the sums
//   are shifted right by FRACTION_WIDTH and narrowed to RESULT_CELL_WIDTH.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   bus    - matrix_vector_product_if.slave (operands, result, error)
// Build option:
//   MATRIX_VECTOR_SATURATE_EN - overflowing cells clamp to signed max/min;
//   otherwise they keep their low RESULT_CELL_WIDTH bits. error flags either way.
module matrix_vector_product #(
   parameter int MATRIX_HEIGHT     = 4,
   parameter int MATRIX_WIDTH      = 4,
   parameter int MATRIX_CELL_WIDTH = 8,
   parameter int VECTOR_CELL_WIDTH = 8,
   parameter int RESULT_CELL_WIDTH = 8,
   parameter int FRACTION_WIDTH    = 4,
   parameter int TILING_ROW        = 1,
   parameter int TILING_COL        = 1
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   matrix_vector_product_if.slave bus
);
   localparam int H         = MATRIX_HEIGHT;
   localparam int W         = MATRIX_WIDTH;
   localparam int MC        = MATRIX_CELL_WIDTH;
   localparam int VC        = VECTOR_CELL_WIDTH;
   localparam int RC        = RESULT_CELL_WIDTH;
   localparam int PW        = MC + VC;
   // Wide enough for W worst-case products, so the sum never wraps.
   localparam int ACC_W     = PW + $clog2(W) + 1;
   localparam int ROW_TILES = (H + TILING_ROW - 1) / TILING_ROW;
   localparam int COL_TILES = (W + TILING_COL - 1) / TILING_COL;
   localparam int RCW       = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
   localparam int CCW       = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic [H*W*MC-1:0]            matrix_q, matrix_d;
   logic [W*VC-1:0]              vector_q, vector_d;
   logic                         matrix_set_q, matrix_set_d;
   logic                         vector_set_q, vector_set_d;
   logic [RCW-1:0]               row_ctr_q, row_ctr_d;
   logic [CCW-1:0]               col_ctr_q, col_ctr_d;
   logic [H-1:0][ACC_W-1:0]      acc_q, acc_d;
   logic [H*RC-1:0]              result_q, result_d;
   logic                         error_q, error_d;

   logic [H-1:0][W-1:0][PW-1:0]  prod;
   logic [H-1:0][W-1:0]          hit;
   logic [H-1:0][ACC_W-1:0]      acc_sum;
   logic [H-1:0][RC-1:0]         conv_cell;
   logic [H-1:0]                 conv_ovf;

   // Per-cell full-precision products and tile membership. Only real cells
   // exist here, so lanes of a partial tile past H or W add nothing.
   for (genvar i = 0; i < H; i++) begin : g_row
      for (genvar j = 0; j < W; j++) begin : g_col
         logic [MC-1:0] m_c;
         logic [VC-1:0] v_c;
         assign m_c = matrix_q[(i*W+j)*MC +: MC];
         assign v_c = vector_q[j*VC +: VC];
         assign prod[i][j] = $signed({{VC{m_c[MC-1]}}, m_c}) *
                             $signed({{MC{v_c[VC-1]}}, v_c});
         assign hit[i][j]  = (row_ctr_q == RCW'(i / TILING_ROW)) &&
                             (col_ctr_q == CCW'(j / TILING_COL));
      end

      // Narrowing: value fits when every bit above the result sign bit
      // matches it.
      logic [ACC_W-1:0] sh;
      logic             fits;
      assign sh   = $signed(acc_sum[i]) >>> FRACTION_WIDTH;
      assign fits = (sh[ACC_W-1:RC-1] == '0) || (sh[ACC_W-1:RC-1] == '1);
      assign conv_ovf[i] = ~fits;
`ifdef MATRIX_VECTOR_SATURATE_EN
      assign conv_cell[i] = fits          ? sh[RC-1:0] :
                            sh[ACC_W-1]   ? {1'b1, {(RC-1){1'b0}}} :
                                            {1'b0, {(RC-1){1'b1}}};
`else
      assign conv_cell[i] = sh[RC-1:0];
`endif
   end

   // Accumulators plus this cycle's tile.
   always_comb begin
      acc_sum = acc_q;
      for (int i = 0; i < H; i++) begin
         for (int j = 0; j < W; j++) begin
            if (hit[i][j]) begin
               acc_sum[i] = acc_sum[i] +
                            {{(ACC_W-PW){prod[i][j][PW-1]}}, prod[i][j]};
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      matrix_d     = matrix_q;
      vector_d     = vector_q;
      matrix_set_d = matrix_set_q;
      vector_set_d = vector_set_q;
      row_ctr_d    = row_ctr_q;
      col_ctr_d    = col_ctr_q;
      acc_d        = acc_q;
      result_d     = result_q;
      error_d      = error_q;
      case (state_q)
         IDLE: begin
            acc_d     = '0;
            row_ctr_d = '0;
            col_ctr_d = '0;
            error_d   = 1'b0;
            if (bus.matrix_valid && !matrix_set_q) begin
               matrix_d     = bus.matrix;
               matrix_set_d = 1'b1;
            end
            if (bus.vector_valid && !vector_set_q) begin
               vector_d     = bus.vector;
               vector_set_d = 1'b1;
            end
            // Start only once both flags are already registered.
            if (matrix_set_q && vector_set_q) state_d = CALC;
         end
         CALC: begin
            acc_d = acc_sum;
            if (col_ctr_q == CCW'(COL_TILES - 1)) begin
               col_ctr_d = '0;
               if (row_ctr_q == RCW'(ROW_TILES - 1)) begin
                  row_ctr_d = '0;
                  state_d   = DONE;
                  result_d  = conv_cell;
                  error_d   = |conv_ovf;
               end else begin
                  row_ctr_d = row_ctr_q + RCW'(1);
               end
            end else begin
               col_ctr_d = col_ctr_q + CCW'(1);
            end
         end
         DONE: begin
            if (bus.result_ready) begin
               matrix_set_d = 1'b0;
               vector_set_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         matrix_q     <= '0;
         vector_q     <= '0;
         matrix_set_q <= 1'b0;
         vector_set_q <= 1'b0;
         row_ctr_q    <= '0;
         col_ctr_q    <= '0;
         acc_q        <= '0;
         result_q     <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         matrix_q     <= matrix_d;
         vector_q     <= vector_d;
         matrix_set_q <= matrix_set_d;
         vector_set_q <= vector_set_d;
         row_ctr_q    <= row_ctr_d;
         col_ctr_q    <= col_ctr_d;
         acc_q        <= acc_d;
         result_q     <= result_d;
         error_q      <= error_d;
      end
   end

   assign bus.matrix_ready = ~matrix_set_q;
   assign bus.vector_ready = ~vector_set_q;
   assign bus.result_valid = (state_q == DONE);
   assign bus.result       = result_q;
   assign bus.error        = error_q;
endmodule

// File: tb/tb_matrix_vector_product.sv
// tb_matrix_vector_product
//   Drives a default-tiled instance (A) and a 3x3-tiled instance (B) with the
//   same operands and compares both against an integer reference model.
module tb_matrix_vector_product;
   localparam int H  = 4;
   localparam int W  = 4;
   localparam int MC = 8;
   localparam int VC = 8;
   localparam int RC = 8;
   localparam int FW = 4;
   localparam int LAT_A = H * W + 1;
   localparam int LAT_B = ((H + 2) / 3) * ((W + 2) / 3) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [H*W*MC-1:0] m_drv = '0;
   logic [W*VC-1:0]   v_drv = '0;
   logic              mv = 1'b0, vv = 1'b0, rr = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   matrix_vector_product_if #(.MATRIX_HEIGHT(H), .MATRIX_WIDTH(W),
      .MATRIX_CELL_WIDTH(MC), .VECTOR_CELL_WIDTH(VC),
      .RESULT_CELL_WIDTH(RC)) ifa ();
   matrix_vector_product_if #(.MATRIX_HEIGHT(H), .MATRIX_WIDTH(W),
      .MATRIX_CELL_WIDTH(MC), .VECTOR_CELL_WIDTH(VC),
      .RESULT_CELL_WIDTH(RC)) ifb ();

   assign ifa.matrix = m_drv;  assign ifb.matrix = m_drv;
   assign ifa.vector = v_drv;  assign ifb.vector = v_drv;
   assign ifa.matrix_valid = mv; assign ifb.matrix_valid = mv;
   assign ifa.vector_valid = vv; assign ifb.vector_valid = vv;
   assign ifa.result_ready = rr; assign ifb.result_ready = rr;

   matrix_vector_product #(.MATRIX_HEIGHT(H), .MATRIX_WIDTH(W),
      .MATRIX_CELL_WIDTH(MC), .VECTOR_CELL_WIDTH(VC), .RESULT_CELL_WIDTH(RC),
      .FRACTION_WIDTH(FW), .TILING_ROW(1), .TILING_COL(1)) u_dut_a (
      .clk_i (clk), .rst_ni(rst_n), .bus(ifa));

   matrix_vector_product #(.MATRIX_HEIGHT(H), .MATRIX_WIDTH(W),
      .MATRIX_CELL_WIDTH(MC), .VECTOR_CELL_WIDTH(VC), .RESULT_CELL_WIDTH(RC),
      .FRACTION_WIDTH(FW), .TILING_ROW(3), .TILING_COL(3)) u_dut_b (
      .clk_i (clk), .rst_ni(rst_n), .bus(ifb));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer dot products, floor-shift, then range check.
   task automatic model(input logic [H*W*MC-1:0] m, input logic [W*VC-1:0] v,
                        output logic [H*RC-1:0] r, output logic e);
      r = '0;
      e = 1'b0;
      for (int i = 0; i < H; i++) begin
         int s, q, a, b;
         s = 0;
         for (int j = 0; j < W; j++) begin
            a = $signed(m[(i*W+j)*MC +: MC]);
            b = $signed(v[j*VC +: VC]);
            s += a * b;
         end
         q = s >>> FW;
         if (q > 127 || q < -128) begin
            e = 1'b1;
`ifdef MATRIX_VECTOR_SATURATE_EN
            q = (q > 127) ? 127 : -128;
`endif
         end
         r[i*RC +: RC] = q[RC-1:0];
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_a"}, {ifa.result, ifa.error, ifa.result_valid,
                        ifa.matrix_ready, ifa.vector_ready}, {32'h0, 4'b0011});
      chk({tag, "_b"}, {ifb.result, ifb.error, ifb.result_valid,
                        ifb.matrix_ready, ifb.vector_ready}, {32'h0, 4'b0011});
   endtask

   // One transaction on both instances. stagger>0 sends the vector that
   // many cycles ahead of the matrix; bp holds result_ready low.
   task automatic txn(input string tag, input logic [H*W*MC-1:0] m,
                      input logic [W*VC-1:0] v, input int stagger, input bit bp);
      logic [H*RC-1:0] er;
      logic            ee;
      bit              seen_a, seen_b, stable;
      model(m, v, er, ee);
      rr = 1'b0;
      @(negedge clk);
      if (stagger > 0) begin
         v_drv = v; vv = 1'b1;
         @(posedge clk); #1 vv = 1'b0;
         @(negedge clk);
         chk({tag, "_hold_rdy"}, {ifa.matrix_ready, ifa.vector_ready,
                                  ifb.matrix_ready, ifb.vector_ready}, 4'b1010);
         repeat (stagger - 1) @(negedge clk);
         m_drv = m; mv = 1'b1;
      end else begin
         m_drv = m; v_drv = v; mv = 1'b1; vv = 1'b1;
      end
      @(posedge clk);
      #1 mv = 1'b0; vv = 1'b0; rr = !bp;
      seen_a = 0; seen_b = 0;
      for (int k = 1; k <= 60 && !(seen_a && seen_b); k++) begin
         @(posedge clk); @(negedge clk);
         if (!seen_a && ifa.result_valid) begin
            seen_a = 1;
            chk({tag, "_lat_a"}, k, LAT_A);
            chk({tag, "_res_a"}, ifa.result, er);
            chk({tag, "_err_a"}, ifa.error, ee);
         end
         if (!seen_b && ifb.result_valid) begin
            seen_b = 1;
            chk({tag, "_lat_b"}, k, LAT_B);
            chk({tag, "_res_b"}, ifb.result, er);
            chk({tag, "_err_b"}, ifb.error, ee);
         end
      end
      if (!seen_a) chk({tag, "_timeout_a"}, 0, 1);
      if (!seen_b) chk({tag, "_timeout_b"}, 0, 1);
      if (bp) begin
         stable = 1;
         repeat (10) begin
            @(negedge clk);
            if (!(ifa.result_valid && ifa.result == er && ifa.error == ee &&
                  !ifa.matrix_ready && !ifa.vector_ready)) stable = 0;
            if (!(ifb.result_valid && ifb.result == er && ifb.error == ee &&
                  !ifb.matrix_ready && !ifb.vector_ready)) stable = 0;
         end
         chk({tag, "_bp_stable"}, stable, 1);
      end
      rr = 1'b1;
      @(posedge clk); @(negedge clk);
      chk({tag, "_rdy_after"}, {ifa.matrix_ready, ifa.vector_ready, ifa.result_valid,
                                ifb.matrix_ready, ifb.vector_ready, ifb.result_valid},
          6'b110110);
   endtask

   logic [H*W*MC-1:0] m_id, m_t;
   logic [W*VC-1:0]   v_t;
   bit                saw_valid;

   initial begin
      m_id = '0;
      for (int i = 0; i < H; i++) m_id[(i*W+i)*MC +: MC] = 8'h10;

      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;

      txn("identity", m_id, 32'h40302010, 0, 0);

      m_t = '0;
      for (int j = 0; j < W; j++) m_t[j*MC +: MC] = 8'hF0;
      txn("signed", m_t, 32'h10101010, 0, 0);

      m_t = {(H*W){8'h70}};
      txn("overflow", m_t, {W{8'h70}}, 0, 0);

      txn("backpressure", m_id, 32'hE0F01020, 5, 1);

      for (int n = 0; n < 8; n++) begin
         for (int c = 0; c < H*W; c++)
            m_t[c*MC +: MC] = (n % 2) ? 8'($urandom_range(0, 255))
                                      : 8'(int'($urandom_range(0, 64)) - 32);
         for (int c = 0; c < W; c++)
            v_t[c*VC +: VC] = (n % 2) ? 8'($urandom_range(0, 255))
                                      : 8'(int'($urandom_range(0, 64)) - 32);
         txn($sformatf("rand%0d", n), m_t, v_t, n % 3, n == 5);
      end

      // Abort in CALC cycle 3: operands go in, reset hits, nothing comes out.
      @(negedge clk);
      m_drv = m_id; v_drv = 32'h04030201; mv = 1'b1; vv = 1'b1; rr = 1'b1;
      @(posedge clk); #1 mv = 1'b0; vv = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_idle("mid_reset");
      @(negedge clk); rst_n = 1'b1;
      saw_valid = 0;
      repeat (20) begin
         @(negedge clk);
         if (ifa.result_valid || ifb.result_valid) saw_valid = 1;
      end
      chk("mid_reset_no_valid", saw_valid, 0);
      chk_idle("post_abort");

      txn("identity2", m_id, 32'h7F017FF0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
